// File: rtl/tenthirty_pkg.sv
// Shared types and helpers for the ten-and-a-half table controller.
package tenthirty_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEAL    = 3'd1,
    PLAY    = 3'd2,
    DEALER  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int TARGET_HALF_DEF       = 21;
  localparam int DEALER_STAND_HALF_DEF = 14;

  // Pip cards count their face value, court cards count half a point.
  function automatic logic [6:0] card_half(input logic [3:0] rank);
    if (rank >= 4'd11) return 7'd1;
    return {2'b00, rank, 1'b0};
  endfunction

endpackage

// File: rtl/tenthirty_hand.sv
// One hand: saturating half-point total, card count and stand/bust flags.
module tenthirty_hand #(
  parameter int TARGET_HALF = 21,
  parameter int MAX_CARDS   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [6:0] half_i,
  output logic [6:0] total_o,
  output logic [2:0] ncards_o,
  output logic       bust_o,
  output logic       at_target_o,
  output logic       full_o
);

  logic [6:0] total_q, total_d;
  logic [2:0] ncards_q, ncards_d;
  logic [7:0] sum;

  always_comb begin
    sum      = {1'b0, total_q} + {1'b0, half_i};
    total_d  = total_q;
    ncards_d = ncards_q;
    if (clear_i) begin
      total_d  = '0;
      ncards_d = '0;
    end else if (add_i) begin
      total_d = sum[7] ? 7'h7f : sum[6:0];
      if (ncards_q != 3'd7) ncards_d = ncards_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q  <= '0;
      ncards_q <= '0;
    end else begin
      total_q  <= total_d;
      ncards_q <= ncards_d;
    end
  end

  assign total_o     = total_q;
  assign ncards_o    = ncards_q;
  assign bust_o      = total_q > 7'(TARGET_HALF);
  assign at_target_o = total_q == 7'(TARGET_HALF);
  assign full_o      = ncards_q >= 3'(MAX_CARDS);

endmodule

// File: rtl/tenthirty_table_ctrl.sv
// Multi-seat ten-and-a-half table: deal, player turns, dealer threshold play,
// round scoring and game-over tracking, with a req/ack card source.
module tenthirty_table_ctrl
  import tenthirty_pkg::*;
#(
  parameter int N_SEATS           = 2,
  parameter int MAX_CARDS         = 5,
  parameter int TARGET_HALF       = TARGET_HALF_DEF,
  parameter int DEALER_STAND_HALF = DEALER_STAND_HALF_DEF,
  parameter int ROUNDS            = 4,
  parameter int SEAT_W            = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit,
  input  logic               stand,
  output logic               card_req,
  input  logic               card_ack,
  input  logic [3:0]         card_val,
  output logic [SEAT_W-1:0]  cur_seat,
  output logic [6:0]         cur_total,
  output logic [2:0]         cur_ncards,
  output logic [2:0]         state_o,
  output logic [2:0]         round_cnt,
  output logic               result_valid,
  output logic [N_SEATS-1:0] win_mask,
  output logic [N_SEATS:0]   bust_mask,
  output logic               game_done
);

  localparam int NH = N_SEATS + 1;
  localparam logic [SEAT_W-1:0] DEALER_SEAT = SEAT_W'(N_SEATS);
  localparam logic [SEAT_W-1:0] LAST_SEAT   = SEAT_W'(N_SEATS - 1);

  state_e             state_q, state_d;
  logic [SEAT_W-1:0]  seat_q, seat_d;
  logic               req_q, req_d;
  logic [2:0]         round_q, round_d;
  logic [N_SEATS-1:0] win_q, win_d, win_calc;

  logic [6:0] h_total  [NH];
  logic [2:0] h_ncards [NH];
  logic [NH-1:0] h_bust, h_target, h_full, h_add;
  logic       clear_hands, ack_ok, all_seats_bust;
  logic [6:0] card_pts, sel_total;
  logic [2:0] sel_ncards;
  logic       sel_bust, sel_target, sel_full;

  // Out-of-range ranks are dropped so the request stays open for a retry.
  assign ack_ok   = req_q && card_ack && (card_val != 4'd0) && (card_val <= 4'd13);
  assign card_pts = card_half(card_val);

  generate
    for (genvar gi = 0; gi < NH; gi++) begin : g_hand
      assign h_add[gi] = ack_ok && (seat_q == SEAT_W'(gi));
      tenthirty_hand #(
        .TARGET_HALF (TARGET_HALF),
        .MAX_CARDS   (MAX_CARDS)
      ) u_hand (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_hands),
        .add_i       (h_add[gi]),
        .half_i      (card_pts),
        .total_o     (h_total[gi]),
        .ncards_o    (h_ncards[gi]),
        .bust_o      (h_bust[gi]),
        .at_target_o (h_target[gi]),
        .full_o      (h_full[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_total  = '0;
    sel_ncards = '0;
    sel_bust   = 1'b0;
    sel_target = 1'b0;
    sel_full   = 1'b0;
    for (int s = 0; s < NH; s++) begin
      if (seat_q == SEAT_W'(s)) begin
        sel_total  = h_total[s];
        sel_ncards = h_ncards[s];
        sel_bust   = h_bust[s];
        sel_target = h_target[s];
        sel_full   = h_full[s];
      end
    end
    for (int s = 0; s < N_SEATS; s++) begin
      win_calc[s] = !h_bust[s] && (h_bust[N_SEATS] || (h_total[s] > h_total[N_SEATS]));
    end
    all_seats_bust = &h_bust[N_SEATS-1:0];
  end

  always_comb begin
    state_d     = state_q;
    seat_d      = seat_q;
    req_d       = req_q;
    round_d     = round_q;
    win_d       = win_q;
    clear_hands = 1'b0;
    if (ack_ok) req_d = 1'b0;

    unique case (state_q)
      IDLE, COMPARE: begin
        if (start) begin
          if (state_q == COMPARE && round_q >= 3'(ROUNDS)) begin
            state_d = DONE;
          end else begin
            state_d     = DEAL;
            seat_d      = '0;
            round_d     = round_q + 3'd1;
            win_d       = '0;
            clear_hands = 1'b1;
          end
        end
      end
      // A hand with no card yet still needs one; once it lands, move on.
      DEAL: begin
        if (!req_q) begin
          if (sel_ncards == 3'd0) begin
            req_d = 1'b1;
          end else if (seat_q == DEALER_SEAT) begin
            state_d = PLAY;
            seat_d  = '0;
          end else begin
            seat_d = seat_q + 1'b1;
          end
        end
      end
      PLAY: begin
        if (!req_q) begin
          if (stand || sel_bust || sel_target || sel_full) begin
            seat_d = seat_q + 1'b1;
            if (seat_q == LAST_SEAT) state_d = DEALER;
          end else if (hit) begin
            req_d = 1'b1;
          end
        end
      end
      DEALER: begin
        if (!req_q) begin
          if (!all_seats_bust && sel_total < 7'(DEALER_STAND_HALF) &&
              sel_ncards < 3'(MAX_CARDS)) begin
            req_d = 1'b1;
          end else begin
            state_d = COMPARE;
            win_d   = win_calc;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seat_q  <= '0;
      req_q   <= 1'b0;
      round_q <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      seat_q  <= seat_d;
      req_q   <= req_d;
      round_q <= round_d;
      win_q   <= win_d;
    end
  end

  assign card_req     = req_q;
  assign cur_seat     = seat_q;
  assign cur_total    = sel_total;
  assign cur_ncards   = sel_ncards;
  assign state_o      = state_q;
  assign round_cnt    = round_q;
  assign result_valid = state_q == COMPARE;
  assign win_mask     = win_q;
  assign bust_mask    = h_bust;
  assign game_done    = state_q == DONE;

endmodule

// File: tb/tb_tenthirty_table_ctrl.sv
// Self-checking bench: scripted rounds from a vector table, handshake corner
// cases, and randomized rounds scored by a game-rule model.
module tb_tenthirty_table_ctrl;

  localparam int TGT  = 21;
  localparam int DSH  = 14;
  localparam int MAXC = 5;

  logic       clk = 1'b0;
  logic       rst_n, start, hit, stand, card_ack;
  logic [3:0] card_val;
  logic       card_req, result_valid, game_done;
  logic [1:0] cur_seat, win_mask;
  logic [6:0] cur_total;
  logic [2:0] cur_ncards, state_o, round_cnt, bust_mask;

  always #5 clk = ~clk;

  tenthirty_table_ctrl #(
    .N_SEATS(2), .MAX_CARDS(MAXC), .TARGET_HALF(TGT),
    .DEALER_STAND_HALF(DSH), .ROUNDS(4), .SEAT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .stand(stand),
    .card_req(card_req), .card_ack(card_ack), .card_val(card_val),
    .cur_seat(cur_seat), .cur_total(cur_total), .cur_ncards(cur_ncards),
    .state_o(state_o), .round_cnt(round_cnt), .result_valid(result_valid),
    .win_mask(win_mask), .bust_mask(bust_mask), .game_done(game_done)
  );

  typedef struct packed {
    logic [3:0]  d0, d1, dd;
    logic [15:0] h0;
    logic [2:0]  n0;
    logic [15:0] h1;
    logic [2:0]  n1;
    logic [15:0] dc;
    logic [1:0]  ew;
    logic [2:0]  eb;
    logic [6:0]  et0, et1, etd;
  } vec_t;

  vec_t vecs [4];
  int checks = 0;
  int errors = 0;

  int deal_r [3];
  int hit_r  [2][5];
  int nhit   [2];
  int dlr_r  [6];
  int mod_t  [3];
  int mod_n  [3];
  int obs_t  [3];
  int obs_w, obs_b, mod_w, mod_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(); start = 1'b1; tick(); start = 1'b0; endtask
  task automatic pulse_hit();   hit   = 1'b1; tick(); hit   = 1'b0; endtask
  task automatic pulse_stand(); stand = 1'b1; tick(); stand = 1'b0; endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (card_req !== 1'b1 && t < 40) begin tick(); t++; end
    ok = (card_req === 1'b1);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout card_req=%0d expected=1", card_req);
    end
  endtask

  task automatic serve_card(input int rank, input int dly);
    bit ok;
    wait_req(ok);
    if (ok) begin
      repeat (dly) tick();
      card_ack = 1'b1;
      card_val = 4'(rank);
      tick();
      card_ack = 1'b0;
      card_val = 4'd0;
    end
  endtask

  function automatic int half_of(input int r);
    return (r >= 11) ? 1 : 2 * r;
  endfunction

  function automatic bit auto_stand(input int t, input int n);
    return (t >= TGT) || (n >= MAXC);
  endfunction

  // Plays one round from the global card/decision arrays, tracking the
  // expected game by the rules and capturing what the DUT shows.
  task automatic play_round();
    int k;
    pulse_start();
    for (int s = 0; s < 3; s++) begin
      serve_card(deal_r[s], $urandom_range(0, 2));
      mod_t[s] = half_of(deal_r[s]);
      mod_n[s] = 1;
    end
    tick();
    for (int s = 0; s < 2; s++) begin
      k = 0;
      while (k < nhit[s] && !auto_stand(mod_t[s], mod_n[s])) begin
        pulse_hit();
        serve_card(hit_r[s][k], $urandom_range(0, 3));
        mod_t[s] += half_of(hit_r[s][k]);
        mod_n[s]++;
        k++;
      end
      obs_t[s] = int'(cur_total);
      tick();
      if (!auto_stand(mod_t[s], mod_n[s])) begin
        chk("seat_hold", int'(cur_seat), s);
        pulse_stand();
      end
      chk("seat_advance", int'(cur_seat), s + 1);
    end
    k = 0;
    if (!(mod_t[0] > TGT && mod_t[1] > TGT)) begin
      while (mod_t[2] < DSH && mod_n[2] < MAXC) begin
        serve_card(dlr_r[k], $urandom_range(0, 2));
        mod_t[2] += half_of(dlr_r[k]);
        mod_n[2]++;
        k++;
      end
    end
    tick(2);
    chk("cmp_state", int'(state_o), 4);
    chk("cmp_req", int'(card_req), 0);
    chk("cmp_valid", int'(result_valid), 1);
    chk("cmp_seat", int'(cur_seat), 2);
    obs_t[2] = int'(cur_total);
    obs_w    = int'(win_mask);
    obs_b    = int'(bust_mask);
    mod_w = 0;
    mod_b = 0;
    for (int s = 0; s < 3; s++) if (mod_t[s] > TGT) mod_b |= (1 << s);
    for (int s = 0; s < 2; s++)
      if (mod_t[s] <= TGT && (mod_t[2] > TGT || mod_t[s] > mod_t[2])) mod_w |= (1 << s);
    $display("round %0d totals %0d/%0d/%0d win=%0d bust=%0d", round_cnt,
             obs_t[0], obs_t[1], obs_t[2], obs_w, obs_b);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req"},   int'(card_req), 0);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_win"},   int'(win_mask), 0);
    chk({tag, "_bust"},  int'(bust_mask), 0);
    chk({tag, "_round"}, int'(round_cnt), 0);
    chk({tag, "_seat"},  int'(cur_seat), 0);
    chk({tag, "_total"}, int'(cur_total), 0);
    chk({tag, "_done"},  int'(game_done), 0);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_state"}, int'(state_o), 5);
    chk({tag, "_done"},  int'(game_done), 1);
    chk({tag, "_round"}, int'(round_cnt), 4);
    chk({tag, "_req"},   int'(card_req), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; stand = 1'b0;
    card_ack = 1'b0; card_val = 4'd0;

    vecs[0] = '{d0:4'd3, d1:4'd5, dd:4'd2, h0:16'h0007, n0:3'd1, h1:16'h000C, n1:3'd1,
                dc:16'h0006, ew:2'b01, eb:3'b000, et0:7'd20, et1:7'd11, etd:7'd16};
    vecs[1] = '{d0:4'd10, d1:4'd4, dd:4'd8, h0:16'h000B, n0:3'd1, h1:16'h0005, n1:3'd1,
                dc:16'h0000, ew:2'b11, eb:3'b000, et0:7'd21, et1:7'd18, etd:7'd16};
    vecs[2] = '{d0:4'd11, d1:4'd2, dd:4'd1, h0:16'hCBDC, n0:3'd4, h1:16'h0003, n1:3'd1,
                dc:16'hBCDD, ew:2'b10, eb:3'b000, et0:7'd5, et1:7'd10, etd:7'd6};
    vecs[3] = '{d0:4'd9, d1:4'd10, dd:4'd3, h0:16'h0004, n0:3'd1, h1:16'h0002, n1:3'd1,
                dc:16'h0000, ew:2'b00, eb:3'b011, et0:7'd26, et1:7'd24, etd:7'd6};

    do_reset();
    check_reset_state("reset");

    // Ack without an outstanding request must not touch any hand.
    card_ack = 1'b1; card_val = 4'd5; tick(); card_ack = 1'b0; card_val = 4'd0;
    chk("idle_ack_total", int'(cur_total), 0);
    chk("idle_ack_req", int'(card_req), 0);

    // Handshake corner cases during the deal of round 1.
    pulse_start();
    chk("start_round", int'(round_cnt), 1);
    wait_req(ok);
    tick(7);
    chk("req_hold", int'(card_req), 1);
    card_ack = 1'b1; card_val = 4'd0; tick(); card_ack = 1'b0;
    chk("bad0_req", int'(card_req), 1);
    chk("bad0_ncards", int'(cur_ncards), 0);
    card_ack = 1'b1; card_val = 4'd14; tick(); card_ack = 1'b0; card_val = 4'd0;
    chk("bad14_req", int'(card_req), 1);
    card_ack = 1'b1; card_val = 4'd13; tick(); card_ack = 1'b0; card_val = 4'd0;
    chk("k_req_drop", int'(card_req), 0);
    chk("k_total", int'(cur_total), 1);
    chk("k_ncards", int'(cur_ncards), 1);
    serve_card(5, 1);
    serve_card(2, 0);
    tick();
    chk("play_state", int'(state_o), 2);
    hit = 1'b1; stand = 1'b1; tick(); hit = 1'b0; stand = 1'b0;
    chk("hitstand_seat", int'(cur_seat), 1);
    tick();
    chk("hitstand_noreq", int'(card_req), 0);
    pulse_hit();
    pulse_hit();
    serve_card(3, 2);
    tick(2);
    chk("dup_hit_req", int'(card_req), 0);
    chk("dup_hit_ncards", int'(cur_ncards), 2);
    chk("dup_hit_total", int'(cur_total), 16);
    pulse_stand();
    serve_card(6, 1);
    tick(2);
    chk("tie_state", int'(state_o), 4);
    chk("tie_win", int'(win_mask), 0);
    chk("tie_bust", int'(bust_mask), 0);
    chk("tie_dealer_total", int'(cur_total), 16);

    // Reset while a request is outstanding.
    pulse_start();
    wait_req(ok);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    tick();
    rst_n = 1'b1;
    tick();

    // Scripted game from the vector table.
    for (int v = 0; v < 4; v++) begin
      deal_r[0] = int'(vecs[v].d0);
      deal_r[1] = int'(vecs[v].d1);
      deal_r[2] = int'(vecs[v].dd);
      nhit[0] = int'(vecs[v].n0);
      nhit[1] = int'(vecs[v].n1);
      for (int k = 0; k < 4; k++) begin
        hit_r[0][k] = int'(vecs[v].h0[4*k +: 4]);
        hit_r[1][k] = int'(vecs[v].h1[4*k +: 4]);
        dlr_r[k]    = int'(vecs[v].dc[4*k +: 4]);
      end
      play_round();
      chk("vec_round", int'(round_cnt), v + 1);
      chk("vec_t0", obs_t[0], int'(vecs[v].et0));
      chk("vec_t1", obs_t[1], int'(vecs[v].et1));
      chk("vec_td", obs_t[2], int'(vecs[v].etd));
      chk("vec_win", obs_w, int'(vecs[v].ew));
      chk("vec_bust", obs_b, int'(vecs[v].eb));
    end
    pulse_start();
    check_done("done");
    pulse_start();
    pulse_hit();
    pulse_stand();
    tick(3);
    check_done("done_hold");

    // Randomized games scored by the rule model.
    for (int g = 0; g < 3; g++) begin
      do_reset();
      for (int r = 0; r < 4; r++) begin
        for (int s = 0; s < 3; s++) deal_r[s] = $urandom_range(1, 13);
        for (int s = 0; s < 2; s++) begin
          nhit[s] = $urandom_range(0, 4);
          for (int k = 0; k < 5; k++) hit_r[s][k] = $urandom_range(1, 13);
        end
        for (int k = 0; k < 6; k++) dlr_r[k] = $urandom_range(1, 13);
        play_round();
        chk("rnd_round", int'(round_cnt), r + 1);
        chk("rnd_t0", obs_t[0], mod_t[0]);
        chk("rnd_t1", obs_t[1], mod_t[1]);
        chk("rnd_td", obs_t[2], mod_t[2]);
        chk("rnd_win", obs_w, mod_w);
        chk("rnd_bust", obs_b, mod_b);
      end
      pulse_start();
      check_done("rnd_done");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tenthirty_table_ctrl.md
Name: tenthirty_table_ctrl

Overview:
- Parametrised game controller for "ten and a half" with N player seats plus one automatic dealer, played over a fixed number of rounds.
- Draws cards from an external card source through a req/ack handshake and keeps per-seat hand totals in half-points.
- Drives auto-stand and bust logic, plays the dealer by a threshold rule, and publishes per-seat win/bust masks.
- Sits between the debounced button pulse generators and the display/LED drivers; it replaces the fixed single-player controller.

Parameters:
- N_SEATS, 2, number of player seats (1..4); the dealer is extra.
- MAX_CARDS, 5, maximum cards per hand; reaching it forces a stand.
- TARGET_HALF, 21, winning total in half-points (10.5).
- DEALER_STAND_HALF, 14, dealer draws while total < this (7.0).
- ROUNDS, 4, rounds per game before DONE.
- SEAT_W, 2, width of seat index; must satisfy 2**SEAT_W > N_SEATS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin a round from IDLE or COMPARE
- hit  in  1  one-cycle pulse: current seat draws
- stand  in  1  one-cycle pulse: current seat stands
- card_req  out  1  request a card from the source
- card_ack  in  1  card_val is valid this cycle
- card_val  in  4  card rank 1..13
- cur_seat  out  SEAT_W  active hand; value N_SEATS denotes the dealer
- cur_total  out  7  active hand total in half-points
- cur_ncards  out  3  cards held by the active hand
- state_o  out  3  FSM state encoding
- round_cnt  out  3  rounds started, 0..ROUNDS
- result_valid  out  1  high throughout COMPARE
- win_mask  out  N_SEATS  bit s = seat s beat the dealer
- bust_mask  out  N_SEATS+1  bit s = hand s exceeded TARGET_HALF; MSB is the dealer
- game_done  out  1  high in DONE

Behaviour:
- Reset (asynchronous): state IDLE; every output 0 except cur_seat=0; all totals, counts and round_cnt cleared.
- Card value: ranks 1..10 add 2*rank half-points; ranks 11..13 add 1. A hand total is 7 bits and saturates at 127. No overflow is possible with MAX_CARDS ≤ 6.
- Handshake:
  - card_req rises in the cycle after a draw decision and stays high until a cycle where card_ack=1.
  - card_val is sampled in that cycle; card_req is 0 the next cycle.
  - An ack with card_val of 0 or >13 is discarded and card_req stays high.
  - card_ack while card_req=0 is ignored.
- States:
  - IDLE: start → DEAL. round_cnt++, all hands and masks cleared.
  - DEAL: one card each to seats 0..N_SEATS-1, then the dealer, sequentially via the handshake → PLAY with seat 0.
  - PLAY(seat s):
    - hit requests a card (one at a time; hit pulses during an outstanding request are ignored).
    - stand, or auto-stand, advances to the next seat. After the last seat → DEALER.
    - Auto-stand is evaluated the cycle after a card lands: total > TARGET_HALF (set bust bit), total == TARGET_HALF, or ncards == MAX_CARDS.
    - hit and stand in the same cycle: stand wins.
  - DEALER:
    - If every seat is bust, go straight to COMPARE.
    - Otherwise auto-draw while total < DEALER_STAND_HALF and ncards < MAX_CARDS; set the dealer bust bit if total > TARGET_HALF.
    - hit and stand are ignored here.
  - COMPARE:
    - Entered with win_mask registered.
    - Seat s wins iff not bust and (dealer bust or seat total > dealer total). Ties and double busts go to the dealer.
    - start with round_cnt < ROUNDS → DEAL (new round). start with round_cnt == ROUNDS → DONE.
  - DONE: game_done=1. Only reset leaves this state.
- Outputs:
  - cur_seat, cur_total and cur_ncards track the active hand in DEAL, PLAY and DEALER.
  - In COMPARE they show the dealer hand.
  - win_mask and bust_mask hold until the next DEAL.
- Inputs outside their legal states are ignored: hit or stand in IDLE, DEAL, COMPARE or DONE; start outside IDLE and COMPARE.
- Reset mid-handshake drops card_req immediately. The source must tolerate an abandoned request.

Decomposition:
- Shared package tenthirty_pkg holds:
  - the state enum (IDLE, DEAL, PLAY, DEALER, COMPARE, DONE);
  - the function card_half(rank) returning 7 bits;
  - the default constants TARGET_HALF and DEALER_STAND_HALF.
- Sub-module tenthirty_hand: one hand's total/count register with clear, add_card and bust/at_target/full flags. Instantiate it N_SEATS+1 times.

Test Plan:
- Reset: assert rst_n=0 mid-handshake → card_req=0, state_o=IDLE, all masks 0, round_cnt=0.
- N_SEATS=2 basic round:
  - Deal 3,5,2 (seat0, seat1, dealer). Seat0 hits 7 → total 20, then stands. Seat1 hits 12 → 11, then stands.
  - Dealer auto-draws 6 → 16 and stops.
  - Expect win_mask=2'b01, bust_mask=3'b000.
- Auto-stand:
  - Seat0 with cards 10 and 11 → total 21. Must advance to seat1 with no stand pulse.
  - Seat0 drawing five half-cards (11,12,13,11,12 → 5) stands at MAX_CARDS.
- Bust path:
  - Seat0 holds 9 and hits 4 → 26 > 21. Bust bit set, auto-advance.
  - With all seats bust, dealer draws nothing. Expect win_mask=0.
- Handshake:
  - Hold card_ack low for 7 cycles → card_req stays high.
  - Ack with card_val=0 → discarded, request persists. Then ack with 13 → total +1.
  - Simultaneous hit+stand → stand.
- Rounds: complete 4 rounds with start pulses. The 4th start in COMPARE → DONE, game_done=1. Further start, hit or stand → no change.
